// File: rtl/fsa_bank_sched.sv
// Frame-level bank scheduler: steers FSA core writes into one of BR_NUM bank RAMs
// and hands completed banks to a single reader with latest-frame semantics.
module fsa_bank_sched #(
  parameter int BR_NUM = 4,
  parameter int BR_IW  = 3,
  parameter int FID_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  core_sof,
  output logic [BR_NUM-1:0]     wr_bmp,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [BR_IW-1:0]      rd_idx,
  output logic [FID_W-1:0]      rd_fid,
  input  logic                  rd_done,
  output logic [2*BR_NUM-1:0]   bank_state,
  output logic [FID_W-1:0]      drop_cnt
);

  typedef enum logic [1:0] {FREE = 2'd0, WRT = 2'd1, RDY = 2'd2, RD = 2'd3} bank_t;

  bank_t             st_q  [BR_NUM];
  bank_t             st_n  [BR_NUM];
  logic [FID_W-1:0]  fid_q [BR_NUM];
  logic [FID_W-1:0]  fid_n [BR_NUM];
  logic [FID_W-1:0]  nfid_q, nfid_n, drop_n;
  logic              rd_valid_n, rd_ack_n;
  logic [BR_IW-1:0]  rd_idx_n;
  logic [FID_W-1:0]  rd_fid_n;
  logic [BR_NUM-1:0] wr_bmp_n;

  logic              wrt_hit, new_hit, free_hit, old_hit, do_pub, do_take;
  logic [BR_IW-1:0]  wrt_idx, new_idx, free_idx, old_idx, take_idx;
  logic [FID_W-1:0]  new_age, old_age, grant_drops;

  // Distance back from next-fid; stays ordered across fid wrap.
  function automatic logic [FID_W-1:0] age(input logic [FID_W-1:0] nf,
                                           input logic [FID_W-1:0] f);
    return nf - f;
  endfunction

  always_comb begin
    st_n        = st_q;
    fid_n       = fid_q;
    nfid_n      = nfid_q;
    drop_n      = drop_cnt;
    rd_valid_n  = rd_valid;
    rd_idx_n    = rd_idx;
    rd_fid_n    = rd_fid;
    rd_ack_n    = 1'b0;
    wrt_hit     = 1'b0;
    wrt_idx     = '0;
    new_hit     = 1'b0;
    new_idx     = '0;
    new_age     = '0;
    free_hit    = 1'b0;
    free_idx    = '0;
    old_hit     = 1'b0;
    old_idx     = '0;
    old_age     = '0;
    grant_drops = '0;
    do_pub      = 1'b0;
    do_take     = 1'b0;
    take_idx    = '0;
    wr_bmp_n    = '0;

    for (int k = 0; k < BR_NUM; k++) begin
      if (st_q[k] == WRT) begin
        wrt_hit = 1'b1;
        wrt_idx = BR_IW'(k);
      end
      if (st_q[k] == RDY && (!new_hit || age(nfid_q, fid_q[k]) < new_age)) begin
        new_hit = 1'b1;
        new_idx = BR_IW'(k);
        new_age = age(nfid_q, fid_q[k]);
      end
    end

    // Release goes first so a same-cycle completion can reuse the bank.
    if (rd_done && rd_valid) begin
      rd_valid_n = 1'b0;
      for (int k = 0; k < BR_NUM; k++)
        if (st_q[k] == RD) st_n[k] = FREE;
    end

    // Grant works on the RDY set as it stood at the start of the cycle.
    if (!rd_valid && rd_req && new_hit) begin
      rd_ack_n   = 1'b1;
      rd_valid_n = 1'b1;
      rd_idx_n   = new_idx;
      for (int k = 0; k < BR_NUM; k++) begin
        if (st_q[k] == RDY) begin
          if (BR_IW'(k) == new_idx) begin
            st_n[k]  = RD;
            rd_fid_n = fid_q[k];
          end else begin
            st_n[k]     = FREE;
            grant_drops = grant_drops + 1'b1;
          end
        end
      end
      drop_n = drop_n + grant_drops;
    end

    for (int k = BR_NUM - 1; k >= 0; k--) begin
      if (st_n[k] == FREE) begin
        free_hit = 1'b1;
        free_idx = BR_IW'(k);
      end
    end
    for (int k = 0; k < BR_NUM; k++) begin
      if (st_n[k] == RDY && (!old_hit || age(nfid_q, fid_q[k]) > old_age)) begin
        old_hit = 1'b1;
        old_idx = BR_IW'(k);
        old_age = age(nfid_q, fid_q[k]);
      end
    end

    if (core_sof && wrt_hit) begin
      if (!en) begin
        do_pub = 1'b1;
      end else if (free_hit) begin
        do_pub   = 1'b1;
        do_take  = 1'b1;
        take_idx = free_idx;
      end else if (old_hit) begin
        do_pub   = 1'b1;
        do_take  = 1'b1;
        take_idx = old_idx;
        drop_n   = drop_n + 1'b1;
      end else begin
        // Nowhere to go: the writer keeps its bank and overwrites this frame.
        drop_n = drop_n + 1'b1;
      end
    end else if (!wrt_hit && en && free_hit) begin
      do_take  = 1'b1;
      take_idx = free_idx;
    end

    for (int k = 0; k < BR_NUM; k++) begin
      if (do_pub && BR_IW'(k) == wrt_idx) begin
        st_n[k]  = RDY;
        fid_n[k] = nfid_q;
      end
      if (do_take && BR_IW'(k) == take_idx) st_n[k] = WRT;
      wr_bmp_n[k] = (st_n[k] == WRT);
    end
    if (do_pub) nfid_n = nfid_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < BR_NUM; k++) st_q[k] <= FREE;
      nfid_q   <= '0;
      drop_cnt <= '0;
      rd_valid <= 1'b0;
      rd_ack   <= 1'b0;
      rd_idx   <= '0;
      rd_fid   <= '0;
      wr_bmp   <= '0;
    end else begin
      st_q     <= st_n;
      nfid_q   <= nfid_n;
      drop_cnt <= drop_n;
      rd_valid <= rd_valid_n;
      rd_ack   <= rd_ack_n;
      rd_idx   <= rd_idx_n;
      rd_fid   <= rd_fid_n;
      wr_bmp   <= wr_bmp_n;
    end
  end

  // Frame stamps are only meaningful while a bank is RDY/RD, so no reset.
  always_ff @(posedge clk) begin
    fid_q <= fid_n;
  end

  always_comb begin
    bank_state = '0;
    for (int k = 0; k < BR_NUM; k++) bank_state[2*k +: 2] = st_q[k];
  end

endmodule

// File: tb/tb_fsa_bank_sched.sv
// Bench for fsa_bank_sched: queue-based scheduler model on a 4-bank instance
// plus directed literal checks on both a 4-bank and a 2-bank instance.
module tb_fsa_bank_sched;

  logic clk = 1'b0;
  logic reset, en, core_sof, rd_req, rd_done;
  logic [3:0] wr_bmp;
  logic       rd_ack, rd_valid;
  logic [2:0] rd_idx;
  logic [3:0] rd_fid;
  logic [7:0] bank_state;
  logic [3:0] drop_cnt;

  logic        en2, sof2, req2, done2;
  logic [1:0]  wr_bmp2;
  logic        ack2, valid2;
  logic [0:0]  idx2;
  logic [15:0] fid2;
  logic [3:0]  state2;
  logic [15:0] drop2;

  int n_chk = 0;
  int n_fail = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  fsa_bank_sched #(.BR_NUM(4), .BR_IW(3), .FID_W(4)) dut_a (
    .clk(clk), .reset(reset), .en(en), .core_sof(core_sof), .wr_bmp(wr_bmp),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .rd_fid(rd_fid), .rd_done(rd_done), .bank_state(bank_state), .drop_cnt(drop_cnt)
  );

  fsa_bank_sched #(.BR_NUM(2), .BR_IW(1), .FID_W(16)) dut_b (
    .clk(clk), .reset(reset), .en(en2), .core_sof(sof2), .wr_bmp(wr_bmp2),
    .rd_req(req2), .rd_ack(ack2), .rd_valid(valid2), .rd_idx(idx2),
    .rd_fid(fid2), .rd_done(done2), .bank_state(state2), .drop_cnt(drop2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- model: writer bank, reader bank, RDY banks queued oldest-first ----
  int         m_wr, m_hold, m_idx;
  int         m_rdyq[$];
  logic [3:0] m_fid [4];
  logic [3:0] m_nfid, m_drop, m_rfid;
  logic       m_ack;

  function automatic bit in_q(input int b);
    for (int j = 0; j < m_rdyq.size(); j++) if (m_rdyq[j] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowest_free();
    for (int b = 0; b < 4; b++)
      if (b != m_wr && b != m_hold && !in_q(b)) return b;
    return -1;
  endfunction

  task automatic publish(input int b);
    m_fid[b[1:0]] = m_nfid;
    m_nfid = m_nfid + 4'd1;
    m_rdyq.push_back(b);
  endtask

  function automatic logic [7:0] exp_state();
    logic [7:0] s;
    logic [1:0] c;
    s = '0;
    for (int b = 0; b < 4; b++) begin
      c = (b == m_wr) ? 2'd1 : (b == m_hold) ? 2'd3 : in_q(b) ? 2'd2 : 2'd0;
      s[2*b +: 2] = c;
    end
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit was_valid;
    int f, o, w;
    if (reset) begin
      m_wr = -1; m_hold = -1; m_idx = 0; m_rdyq.delete();
      m_nfid = '0; m_drop = '0; m_rfid = '0; m_ack = 1'b0;
    end else begin
      m_ack = 1'b0;
      was_valid = (m_hold >= 0);
      if (rd_done && was_valid) m_hold = -1;
      if (!was_valid && rd_req && m_rdyq.size() > 0) begin
        m_hold = m_rdyq[m_rdyq.size() - 1];
        m_idx  = m_hold;
        m_rfid = m_fid[m_hold[1:0]];
        m_drop = m_drop + 4'(m_rdyq.size() - 1);
        m_rdyq.delete();
        m_ack = 1'b1;
      end
      if (core_sof && m_wr >= 0) begin
        w = m_wr;
        if (!en) begin
          publish(w); m_wr = -1;
        end else begin
          f = lowest_free();
          if (f >= 0) begin
            publish(w); m_wr = f;
          end else if (m_rdyq.size() > 0) begin
            o = m_rdyq.pop_front();
            publish(w); m_wr = o; m_drop = m_drop + 4'd1;
          end else begin
            m_drop = m_drop + 4'd1;
          end
        end
      end else if (m_wr < 0 && en) begin
        f = lowest_free();
        if (f >= 0) m_wr = f;
      end
    end
  end

  always @(negedge clk) begin
    if (check_on && !reset) begin
      chk("m_wr_bmp", 32'(wr_bmp), (m_wr >= 0) ? (32'd1 << m_wr) : 32'd0);
      chk("m_bank_state", 32'(bank_state), 32'(exp_state()));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("m_rd_ack", 32'(rd_ack), 32'(m_ack));
      chk("m_rd_valid", 32'(rd_valid), (m_hold >= 0) ? 32'd1 : 32'd0);
      if (m_hold >= 0) begin
        chk("m_rd_idx", 32'(rd_idx), m_idx);
        chk("m_rd_fid", 32'(rd_fid), 32'(m_rfid));
      end
    end
  end

  // ---- directed stimulus ----
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sof_a();
    core_sof = 1'b1; tick(1); core_sof = 1'b0;
  endtask

  task automatic sof_b();
    sof2 = 1'b1; tick(1); sof2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; core_sof = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
    en2 = 1'b0; sof2 = 1'b0; req2 = 1'b0; done2 = 1'b0;
    tick(2);
    chk("rst_wr_bmp", 32'(wr_bmp), 32'h0);
    chk("rst_state", 32'(bank_state), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_valid", 32'(rd_valid), 32'h0);
    chk("rst_ack", 32'(rd_ack), 32'h0);
    chk("rst_idx_fid", {25'd0, rd_idx, rd_fid}, 32'h0);
    chk("rst_b_wr_bmp", 32'(wr_bmp2), 32'h0);
    reset = 1'b0; en = 1'b1; en2 = 1'b1; check_on = 1'b1;
    tick(1);
    chk("alloc_a", 32'(wr_bmp), 32'h1);
    chk("alloc_b", 32'(wr_bmp2), 32'h1);
    tick(3);
    sof_a();
    chk("sof1_wr", 32'(wr_bmp), 32'h2);
    chk("sof1_state", 32'(bank_state), 32'h06);
    tick(4);
    rd_req = 1'b1; tick(1); rd_req = 1'b0;
    chk("grant_ack", 32'(rd_ack), 32'h1);
    chk("grant_idx", 32'(rd_idx), 32'h0);
    chk("grant_fid", 32'(rd_fid), 32'h0);
    chk("grant_valid", 32'(rd_valid), 32'h1);
    chk("grant_state", 32'(bank_state), 32'h07);
    tick(1);
    chk("ack_pulse", 32'(rd_ack), 32'h0);
    rd_done = 1'b1; tick(1); rd_done = 1'b0;
    chk("rel_valid", 32'(rd_valid), 32'h0);
    chk("rel_state", 32'(bank_state), 32'h04);

    // asynchronous reset in the middle of a cycle
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("arst_wr_bmp", 32'(wr_bmp), 32'h0);
    chk("arst_state", 32'(bank_state), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("realloc", 32'(wr_bmp), 32'h1);

    // four frames, no reader: bank 0 recycled on the fourth
    for (int i = 0; i < 4; i++) begin
      tick(3);
      sof_a();
      if (i == 2) chk("three_state", 32'(bank_state), 32'h6A);
    end
    chk("recyc_wr", 32'(wr_bmp), 32'h1);
    chk("recyc_state", 32'(bank_state), 32'hA9);
    chk("recyc_drop", 32'(drop_cnt), 32'h1);
    rd_req = 1'b1; tick(1); rd_req = 1'b0;
    chk("newest_idx", 32'(rd_idx), 32'h3);
    chk("newest_fid", 32'(rd_fid), 32'h3);
    chk("newest_drop", 32'(drop_cnt), 32'h3);
    chk("newest_state", 32'(bank_state), 32'hC1);

    // completion coinciding with release reuses the released bank
    tick(4); sof_a();
    chk("fill0_state", 32'(bank_state), 32'hC6);
    tick(4); sof_a();
    chk("fill1_state", 32'(bank_state), 32'hDA);
    tick(4);
    core_sof = 1'b1; rd_done = 1'b1; tick(1); core_sof = 1'b0; rd_done = 1'b0;
    chk("coinc_state", 32'(bank_state), 32'h6A);
    chk("coinc_wr", 32'(wr_bmp), 32'h8);
    chk("coinc_drop", 32'(drop_cnt), 32'h3);

    // enable dropped mid-frame
    tick(2); en = 1'b0; tick(2);
    sof_a();
    chk("en0_wr", 32'(wr_bmp), 32'h0);
    chk("en0_state", 32'(bank_state), 32'hAA);
    tick(4); sof_a();
    chk("idle_sof_state", 32'(bank_state), 32'hAA);
    chk("idle_sof_drop", 32'(drop_cnt), 32'h3);
    rd_req = 1'b1; tick(1); rd_req = 1'b0;
    chk("en0_grant_fid", 32'(rd_fid), 32'h7);
    chk("en0_grant_drop", 32'(drop_cnt), 32'h6);
    chk("en0_grant_state", 32'(bank_state), 32'hC0);
    en = 1'b1; tick(1);
    chk("en1_wr", 32'(wr_bmp), 32'h1);
    rd_done = 1'b1; tick(1); rd_done = 1'b0;

    // long run with mixed reader traffic; fids wrap several times
    for (int i = 0; i < 48; i++) begin
      en = ((i % 11) != 10);
      core_sof = 1'b1; rd_done = (i % 4 == 1); rd_req = (i % 3 == 0);
      tick(1);
      core_sof = 1'b0; rd_done = 1'b0; rd_req = (i % 5 == 2);
      tick(1);
      rd_req = 1'b0;
      tick(2 + i % 3);
    end
    en = 1'b1;

    // two-bank instance: writer keeps its bank when nothing else is free
    sof_b();
    chk("b_sof1_state", 32'(state2), 32'h6);
    chk("b_sof1_wr", 32'(wr_bmp2), 32'h2);
    tick(4); sof_b();
    chk("b_recyc_state", 32'(state2), 32'h9);
    chk("b_recyc_drop", 32'(drop2), 32'h1);
    req2 = 1'b1; tick(1); req2 = 1'b0;
    chk("b_grant_idx", 32'(idx2), 32'h1);
    chk("b_grant_fid", 32'(fid2), 32'h1);
    chk("b_grant_state", 32'(state2), 32'hD);
    tick(4); sof_b();
    chk("b_stay_wr", 32'(wr_bmp2), 32'h1);
    chk("b_stay_state", 32'(state2), 32'hD);
    chk("b_stay_drop", 32'(drop2), 32'h2);
    done2 = 1'b1; tick(1); done2 = 1'b0;
    chk("b_rel_state", 32'(state2), 32'h1);
    tick(4); sof_b();
    chk("b_pub_state", 32'(state2), 32'h6);
    req2 = 1'b1; tick(1); req2 = 1'b0;
    chk("b_fid_kept", 32'(fid2), 32'h2);
    chk("b_fid_idx", 32'(idx2), 32'h0);
    tick(2);

    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsa_bank_sched.md
# fsa_bank_sched

Frame-level bank scheduler for the FSA column-state block RAMs. It owns the `wr_bmp` bank-select input of the FSA core and decides which of the BR_NUM bank RAMs receives each frame's per-column top/bottom/valid record. Completed banks are published to a single downstream reader (edge extraction or DMA readback) using latest-frame semantics. The block sits between the FSA core's `sof` frame-complete pulse, the bank RAMs and the reader, and reports per-bank state and drop counts.

## Interface
- BR_NUM, 4, number of bank RAMs; legal range 2..8
- BR_IW, 3, bank index width; must satisfy 2^BR_IW >= BR_NUM
- FID_W, 16, frame-id and drop-counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  scheduling enable (level)
- core_sof  in  1  one-cycle pulse from the FSA core on the last pixel write of a frame
- wr_bmp  out  BR_NUM  one-hot bank the core writes; all-zero means the core's writes are discarded
- rd_req  in  1  reader requests a completed bank (level)
- rd_ack  out  1  one-cycle grant pulse
- rd_valid  out  1  reader currently holds a bank
- rd_idx  out  BR_IW  index of the held bank; valid while rd_valid
- rd_fid  out  FID_W  frame id of the held bank; valid while rd_valid
- rd_done  in  1  one-cycle release of the held bank
- bank_state  out  2*BR_NUM  per-bank state, 2 bits per bank, bank 0 in the LSBs
- drop_cnt  out  FID_W  count of completed frames never granted; wraps

## Operation
- Bank states: FREE=0, WRT=1, RDY=2, RD=3. At most one bank is WRT and at most one is RD at any time.
- Reset values: all banks FREE, wr_bmp=0, rd_ack=0, rd_valid=0, rd_idx=0, rd_fid=0, drop_cnt=0, internal next-fid=0.
- Allocation: when no bank is WRT and en=1, the lowest-index FREE bank becomes WRT, and wr_bmp becomes its one-hot.
- Frame completion on core_sof with bank k in WRT:
  - k becomes RDY, stamped with next-fid; next-fid increments.
  - If en=1, a new WRT bank is chosen as the lowest-index FREE bank, excluding k.
  - If no FREE bank exists, the oldest RDY bank other than k is recycled to WRT and drop_cnt increments.
  - If neither exists, k stays WRT and is not published (next-fid is unchanged), and drop_cnt increments.
- core_sof with no WRT bank is ignored.
- Grant: when rd_valid=0, rd_req=1 and at least one RDY bank exists, the newest RDY bank (highest fid) becomes RD.
  - rd_ack pulses, and rd_valid, rd_idx and rd_fid are loaded.
  - All other RDY banks become FREE; drop_cnt adds their count.
- Release: rd_done with rd_valid=1 sets the RD bank to FREE and clears rd_valid. rd_done with rd_valid=0 is ignored.
- en deassertion:
  - A frame in progress completes normally.
  - On its core_sof, no new WRT bank is allocated and wr_bmp becomes 0.
  - RDY and RD banks are unaffected.
- Fid comparison for oldest/newest uses wrap-aware subtraction relative to next-fid.

## Timing
- All outputs are registered. wr_bmp is stable during the core_sof cycle and changes on the following edge. The core's next-frame first write is at least 4 cycles later, so no bank overlap occurs.
- Allocation latency: 1 cycle from en=1 with no WRT bank to wr_bmp nonzero.
- Grant latency: rd_ack is asserted 1 cycle after the cycle in which rd_req=1 and a RDY bank exist.
- Same-cycle event order:
  - rd_done release is applied first.
  - core_sof completion is applied next, and sees the released bank as FREE.
  - Grant evaluation uses the RDY set from before this cycle's completion; the bank completed this cycle becomes grantable next cycle.
  - rd_done and a grant cannot coincide, because a grant requires rd_valid=0.
- Reset asserted mid-frame forces all reset values immediately (asynchronous). The core's partial frame is discarded because wr_bmp=0.

## Test plan
- Reset, en=1, BR_NUM=4 -> wr_bmp=0001 after 1 cycle; core_sof -> bank0 RDY (fid 0), wr_bmp=0010, bank_state=0x06.
- Bank0 RDY, rd_req=1 -> rd_ack pulse next cycle, rd_idx=0, rd_fid=0, rd_valid=1; rd_done -> bank0 FREE, rd_valid=0.
- No reader activity, 4 core_sof pulses -> banks 0,1,2 RDY and then recycled, with drop_cnt=1 after the 4th pulse and the oldest bank (0) as WRT; rd_req -> grant of the fid 3 bank, the others become FREE, drop_cnt=3.
- BR_NUM=2, reader holds bank1, bank0 WRT, core_sof -> bank0 stays WRT, wr_bmp=01 unchanged, drop_cnt+1, next-fid unchanged.
- core_sof and rd_done in the same cycle with all other banks RDY -> the released bank becomes the new WRT, and no drop is counted.
- en=0 mid-frame, then core_sof -> frame published RDY, wr_bmp=0; en=1 -> wr_bmp set to the lowest FREE bank after 1 cycle.
